// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multdiv issue/writeback controller.
package multdiv_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } md_state_e;

    localparam int unsigned CountWidth     = 6;
    localparam int unsigned DefRstatusReg  = 30;
    localparam int unsigned DefMultExcCode = 4;
    localparam int unsigned DefDivExcCode  = 5;
    localparam int unsigned MinRdyCount    = 2;

endpackage

// File: rtl/mdi_wait_counter.sv
// Saturating wait counter with synchronous clear and enable.
module mdi_wait_counter
    import multdiv_pkg::*;
(
    input  logic                  clock,
    input  logic                  clrn,
    input  logic                  clr,
    input  logic                  en,
    output logic [CountWidth-1:0] count
);

    logic [CountWidth-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/multdiv_issue.sv
// Issues one MULT/DIV to multdiv, stalls the pipeline until it completes and
// presents a single writeback beat (result or $rstatus exception code).
module multdiv_issue
    import multdiv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 40,
    parameter int unsigned RSTATUS_REG    = DefRstatusReg,
    parameter int unsigned MULT_EXC_CODE  = DefMultExcCode,
    parameter int unsigned DIV_EXC_CODE   = DefDivExcCode
) (
    input  logic        clock,
    input  logic        clrn,
    input  logic        op_valid,
    input  logic        op_is_div,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  op_rd,
    input  logic        flush,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        md_ctrl_MULT,
    output logic        md_ctrl_DIV,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        stall,
    output logic        pend_valid,
    output logic [4:0]  pend_rd,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    md_state_e             state_q, state_d;
    logic [31:0]           a_q, b_q, result_q;
    logic [4:0]            rd_q;
    logic                  is_div_q, exc_q;
    logic                  latch_op, capture, timeout_hit;
    logic [CountWidth-1:0] count;

    mdi_wait_counter u_wait_counter (
        .clock (clock),
        .clrn  (clrn),
        .clr   (state_q == StIssue),
        .en    (state_q == StWait),
        .count (count)
    );

    always_comb begin
        state_d     = state_q;
        latch_op    = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (op_valid && !flush) begin
                    latch_op = 1'b1;
                    state_d  = StIssue;
                end
            end
            StIssue: state_d = flush ? StIdle : StWait;
            StWait: begin
                // Early RDY is stale: multdiv clears its own counter late.
                if (flush) begin
                    state_d = StIdle;
                end else if (md_resultRDY && (count >= CountWidth'(MinRdyCount))) begin
                    capture = 1'b1;
                    state_d = StDone;
                end else if (count == CountWidth'(TIMEOUT_CYCLES)) begin
                    timeout_hit = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            is_div_q <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_op) begin
                a_q      <= op_a;
                b_q      <= op_b;
                rd_q     <= op_rd;
                is_div_q <= op_is_div;
            end
            if (capture) begin
                result_q <= md_result;
                exc_q    <= md_exception;
            end else if (timeout_hit) begin
                result_q <= '0;
                exc_q    <= 1'b1;
            end
        end
    end

    assign md_operandA  = a_q;
    assign md_operandB  = b_q;
    assign md_ctrl_MULT = (state_q == StIssue) && !is_div_q;
    assign md_ctrl_DIV  = (state_q == StIssue) && is_div_q;

    assign stall = ((state_q == StIdle) && op_valid && !flush) ||
                   (state_q == StIssue) || (state_q == StWait);

    assign pend_valid = (state_q == StIssue) || (state_q == StWait);
    assign pend_rd    = pend_valid ? rd_q : '0;

    always_comb begin
        wb_valid = 1'b0;
        wb_rd    = '0;
        wb_data  = '0;
        if (state_q == StDone) begin
            // r0 is never written; exceptions always go to $rstatus.
            wb_valid = exc_q || (rd_q != '0);
            if (exc_q) begin
                wb_rd   = 5'(RSTATUS_REG);
                wb_data = is_div_q ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);
            end else begin
                wb_rd   = rd_q;
                wb_data = result_q;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_issue.sv
// Directed self-checking bench for multdiv_issue; multdiv responses are driven by hand.
module tb_multdiv_issue;

    logic        clock = 1'b0;
    logic        clrn;
    logic        op_valid, op_is_div, flush;
    logic [31:0] op_a, op_b;
    logic [4:0]  op_rd;
    logic [31:0] md_operandA, md_operandB;
    logic        md_ctrl_MULT, md_ctrl_DIV;
    logic [31:0] md_result;
    logic        md_exception, md_resultRDY;
    logic        stall, pend_valid;
    logic [4:0]  pend_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_cmp = 0;
    int n_bad = 0;
    int mult_cnt = 0;
    int div_cnt = 0;

    multdiv_issue dut (
        .clock        (clock),
        .clrn         (clrn),
        .op_valid     (op_valid),
        .op_is_div    (op_is_div),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_rd        (op_rd),
        .flush        (flush),
        .md_operandA  (md_operandA),
        .md_operandB  (md_operandB),
        .md_ctrl_MULT (md_ctrl_MULT),
        .md_ctrl_DIV  (md_ctrl_DIV),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_resultRDY (md_resultRDY),
        .stall        (stall),
        .pend_valid   (pend_valid),
        .pend_rd      (pend_rd),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (md_ctrl_MULT) mult_cnt <= mult_cnt + 1;
        if (md_ctrl_DIV)  div_cnt  <= div_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Present an op in IDLE, then walk it through ISSUE and WAIT; RDY at count lat.
    task automatic issue_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
        int m0, d0;
        op_valid = 1'b1; op_is_div = is_div; op_a = a; op_b = b; op_rd = rd;
        #1;
        check_eq("stall_on_request", 32'(stall), 32'd1);
        m0 = mult_cnt; d0 = div_cnt;
        tick();
        op_valid = 1'b0; op_a = '0; op_b = '0; op_rd = '0;
        check_eq("ctrl_mult", 32'(md_ctrl_MULT), 32'(!is_div));
        check_eq("ctrl_div", 32'(md_ctrl_DIV), 32'(is_div));
        check_eq("operand_a", md_operandA, a);
        check_eq("operand_b", md_operandB, b);
        check_eq("pend_rd", 32'(pend_rd), 32'(rd));
        tick();
        check_eq("mult_pulses", 32'(mult_cnt - m0), 32'(!is_div));
        check_eq("div_pulses", 32'(div_cnt - d0), 32'(is_div));
        check_eq("pend_valid_wait", 32'(pend_valid), 32'd1);
    endtask

    task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] res, input logic exc,
                          input int lat, input logic exp_wb, input logic [4:0] exp_rd,
                          input logic [31:0] exp_data);
        issue_op(is_div, a, b, rd);
        repeat (lat) tick();
        md_resultRDY = 1'b1; md_result = res; md_exception = exc;
        #1;
        check_eq("stall_wait", 32'(stall), 32'd1);
        tick();
        md_resultRDY = 1'b0; md_result = '0; md_exception = 1'b0;
        check_eq("wb_valid", 32'(wb_valid), 32'(exp_wb));
        if (exp_wb) begin
            check_eq("wb_rd", 32'(wb_rd), 32'(exp_rd));
            check_eq("wb_data", wb_data, exp_data);
        end
        check_eq("stall_done", 32'(stall), 32'd0);
        check_eq("operand_a_done", md_operandA, a);
        tick();
        check_eq("wb_one_beat", 32'(wb_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn = 1'b1; op_valid = 1'b0; op_is_div = 1'b0; op_a = '0; op_b = '0; op_rd = '0;
        flush = 1'b0; md_result = '0; md_exception = 1'b0; md_resultRDY = 1'b0;
        #3 clrn = 1'b0;
        #1;
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("rst_wb_rd", 32'(wb_rd), 32'd0);
        check_eq("rst_wb_data", wb_data, 32'd0);
        check_eq("rst_ctrl", 32'({md_ctrl_MULT, md_ctrl_DIV}), 32'd0);
        check_eq("rst_operand_a", md_operandA, 32'd0);
        check_eq("rst_operand_b", md_operandB, 32'd0);
        check_eq("rst_pend", 32'({pend_valid, pend_rd}), 32'd0);
        tick();
        clrn = 1'b1;
        tick();

        // MULT 7 * -3 -> -21
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b0, 30,
               1'b1, 5'd5, 32'hFFFF_FFEB);
        // DIV by zero -> $rstatus = 5
        run_op(1'b1, 32'd100, 32'd0, 5'd8, 32'd0, 1'b1, 33, 1'b1, 5'd30, 32'd5);
        // MULT overflow -> $rstatus = 4
        run_op(1'b0, 32'h7FFF_FFFF, 32'd2, 5'd9, 32'hFFFF_FFFE, 1'b1, 31,
               1'b1, 5'd30, 32'd4);
        // rd = 0, no exception: no beat
        run_op(1'b0, 32'd2, 32'd3, 5'd0, 32'd6, 1'b0, 5, 1'b0, 5'd0, 32'd0);

        // Stale RDY through WAIT counts 0 and 1 must be ignored
        md_resultRDY = 1'b1; md_result = 32'hDEAD_BEEF;
        issue_op(1'b0, 32'd6, 32'd7, 5'd3);
        tick();
        check_eq("stale_c1_pend", 32'(pend_valid), 32'd1);
        tick();
        check_eq("stale_c2_pend", 32'(pend_valid), 32'd1);
        check_eq("stale_c2_wb", 32'(wb_valid), 32'd0);
        md_resultRDY = 1'b0;
        repeat (2) tick();
        md_resultRDY = 1'b1; md_result = 32'd42;
        tick();
        md_resultRDY = 1'b0; md_result = '0;
        check_eq("stale_wb_valid", 32'(wb_valid), 32'd1);
        check_eq("stale_wb_data", wb_data, 32'd42);
        check_eq("stale_wb_rd", 32'(wb_rd), 32'd3);
        tick();

        // Flush in the 10th WAIT cycle
        issue_op(1'b1, 32'd50, 32'd5, 5'd11);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush_stall", 32'(stall), 32'd0);
        check_eq("flush_pend", 32'(pend_valid), 32'd0);
        check_eq("flush_wb", 32'(wb_valid), 32'd0);
        tick();
        check_eq("flush_wb_after", 32'(wb_valid), 32'd0);
        run_op(1'b0, 32'd3, 32'd4, 5'd6, 32'd12, 1'b0, 20, 1'b1, 5'd6, 32'd12);

        // Flush alongside a request in IDLE: nothing issues
        op_valid = 1'b1; flush = 1'b1;
        #1;
        check_eq("idle_flush_stall", 32'(stall), 32'd0);
        tick();
        op_valid = 1'b0; flush = 1'b0;
        check_eq("idle_flush_pend", 32'(pend_valid), 32'd0);
        tick();

        // Timeout: no RDY, forced exception once count reaches 40
        issue_op(1'b0, 32'd9, 32'd9, 5'd7);
        repeat (40) tick();
        check_eq("timeout_c40_pend", 32'(pend_valid), 32'd1);
        tick();
        check_eq("timeout_wb_valid", 32'(wb_valid), 32'd1);
        check_eq("timeout_wb_rd", 32'(wb_rd), 32'd30);
        check_eq("timeout_wb_data", wb_data, 32'd4);
        tick();

        // Reset in the middle of WAIT
        issue_op(1'b0, 32'd11, 32'd13, 5'd12);
        repeat (5) tick();
        clrn = 1'b0;
        #1;
        check_eq("midrst_stall", 32'(stall), 32'd0);
        check_eq("midrst_pend", 32'({pend_valid, pend_rd}), 32'd0);
        check_eq("midrst_operand_a", md_operandA, 32'd0);
        check_eq("midrst_wb", 32'(wb_valid), 32'd0);
        tick();
        clrn = 1'b1;
        tick();
        run_op(1'b1, 32'd20, 32'd3, 5'd4, 32'd6, 1'b0, 34, 1'b1, 5'd4, 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
